iobus_uart_tx: RTL

Memory-mapped UART transmitter that sits on the OTTER IOBUS as a write-target peripheral beside the LEDs and seven-segment display. The CPU stores a byte to the data address. The block buffers the byte in a one-deep holding register and serializes it on TX as 8N1. A status word is returned to the wrapper's IOBUS_IN read mux for software polling.

---
 rtl/iobus_uart_tx_if.sv | 22 ++
 rtl/iobus_uart_tx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/iobus_uart_tx_if.sv
// OTTER IOBUS bundle as seen by a memory-mapped peripheral.
// The CPU side drives address, write data and strobe. The peripheral returns a read-back word.
interface iobus_uart_tx_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  RD_DATA
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output RD_DATA
  );
endinterface

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the OTTER IOBUS.
// A one-deep holding register feeds a shift register.
// The status word {ovf, hold_full, busy_shift} is returned on RD_DATA for polling.
module iobus_uart_tx #(
  parameter int          CLK_HZ  = 50_000_000,
  parameter int          BAUD    = 115200,
  parameter logic [31:0] DATA_AD = 32'h11000060,
  parameter logic [31:0] STAT_AD = 32'h11000064
) (
  input  logic             CLK,
  input  logic             RST,
  iobus_uart_tx_if.slave   bus,
  output logic             TX,
  output logic             BUSY
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       hold;
  logic             hold_full;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;
  logic             ovf;
  logic             tx_r;

  logic busy_shift;
  logic baud_last;
  logic load;
  logic wr_data;
  logic wr_stat;
  logic accept;
  logic ovf_set;
  logic ovf_clr;
  logic unused_bits;

  assign busy_shift = (state != IDLE);
  assign baud_last  = busy_shift && (baud_cnt == CNT_LAST);
  assign load       = hold_full && ((state == IDLE) || ((state == STOP) && baud_last));

  assign wr_data = bus.IOBUS_WR && (bus.IOBUS_ADDR == DATA_AD);
  assign wr_stat = bus.IOBUS_WR && (bus.IOBUS_ADDR == STAT_AD);
  // A load frees the holding register in the same cycle, so a write on that edge is accepted.
  assign accept  = wr_data && (!hold_full || load);
  assign ovf_set = wr_data && hold_full && !load;
  assign ovf_clr = wr_stat && bus.IOBUS_OUT[2];

  assign bus.RD_DATA = (bus.IOBUS_ADDR == STAT_AD) ? {29'b0, ovf, hold_full, busy_shift} : 32'b0;
  assign TX          = tx_r;
  assign BUSY        = busy_shift | hold_full;
  assign unused_bits = ^bus.IOBUS_OUT[31:8];

  // Holding register: filled by CPU writes and emptied when the shifter takes the byte.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold      <= 8'h00;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= bus.IOBUS_OUT[7:0];
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Sticky overflow flag. A set in the same cycle as a clear takes priority.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Frame FSM: baud timing, bit shifting and the registered TX line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      shift    <= 8'h00;
      bit_idx  <= 3'd0;
      baud_cnt <= '0;
      tx_r     <= 1'b1;
    end else if (load) begin
      shift    <= hold;
      state    <= START;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      tx_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx_r     <= 1'b1;
        end
        START: begin
          if (baud_last) begin
            state    <= DATA;
            bit_idx  <= 3'd0;
            baud_cnt <= '0;
            tx_r     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_r  <= 1'b1;
            end else begin
              tx_r  <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            state    <= IDLE;
            baud_cnt <= '0;
            tx_r     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx_r     <= 1'b1;
        end
      endcase
    end
  end

endmodule
